rs232_reg_responder: RTL and testbench

FPGA-side command responder for the host RS232 register protocol. It sits behind the `UART` core, consuming received bytes and producing reply bytes. It parses 3-byte frames (flow, address, data) and executes writes into an internal 256 x 8 register file. For read frames it returns the stored byte over the UART transmitter. A registered local read port exposes the register file to display logic.

---
 rtl/rs232_reg_responder.sv | 150 +++++++++++++++
 tb/tb_rs232_reg_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_reg_responder.sv
// Host RS232 register-protocol responder: parses flow/addr/data frames from the UART
// receiver, executes writes into a 256x8 register file and answers reads over the UART transmitter.
module rs232_reg_responder #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int ERR_W       = 8
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_DONE,
    input  logic             TX_BUSY,
    output logic [7:0]       TX_DATA,
    output logic             TX_TRG,
    output logic             WR_STB,
    input  logic [7:0]       LOC_ADDR,
    output logic [7:0]       LOC_DATA,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] FLOW_WR = 8'h00;
    localparam logic [7:0] FLOW_RD = 8'h01;

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND} state_t;

    state_t             state_q, state_d;
    logic               isRead_q, isRead_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   errCnt_q, errCnt_d;
    logic [7:0]         txData_q, txData_d;
    logic               txTrg_q, txTrg_d;
    logic [7:0]         mem_q [256];
    logic [7:0]         locData_q;
    logic               errInc;
    logic               memWe;

    always_comb begin
        state_d  = state_q;
        isRead_d = isRead_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        txData_d = txData_q;
        txTrg_d  = 1'b0;
        errInc   = 1'b0;
        memWe    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RX_DONE) begin
                    if (RX_DATA == FLOW_WR || RX_DATA == FLOW_RD) begin
                        isRead_d = (RX_DATA == FLOW_RD);
                        cnt_d    = '0;
                        state_d  = GET_ADDR;
                    end else begin
                        errInc = 1'b1;
                    end
                end
            end
            // A byte landing on the timeout cycle is still accepted.
            GET_ADDR: begin
                if (RX_DONE) begin
                    addr_d  = RX_DATA;
                    cnt_d   = '0;
                    state_d = GET_DATA;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    errInc  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GET_DATA: begin
                if (RX_DONE) begin
                    data_d  = RX_DATA;
                    state_d = EXEC;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    errInc  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                errInc = RX_DONE;
                if (isRead_q) begin
                    txData_d = mem_q[addr_q];
                    state_d  = SEND;
                end else begin
                    memWe   = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND: begin
                errInc = RX_DONE;
                if (!TX_BUSY) begin
                    txTrg_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        errCnt_d = (errInc && errCnt_q != '1) ? errCnt_q + 1'b1 : errCnt_q;
    end

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            isRead_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            errCnt_q <= '0;
            txData_q <= '0;
            txTrg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            isRead_q <= isRead_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            errCnt_q <= errCnt_d;
            txData_q <= txData_d;
            txTrg_q  <= txTrg_d;
        end
    end

    // Register file plus the independent registered local read port.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= '0;
            end
            locData_q <= '0;
        end else begin
            if (memWe) begin
                mem_q[addr_q] <= data_q;
            end
            locData_q <= mem_q[LOC_ADDR];
        end
    end

    assign TX_DATA  = txData_q;
    assign TX_TRG   = txTrg_q;
    assign WR_STB   = memWe;
    assign LOC_DATA = locData_q;
    assign ERR_CNT  = errCnt_q;

endmodule

// File: tb/tb_rs232_reg_responder.sv
// Self-checking bench for rs232_reg_responder: directed protocol scenarios plus randomized
// frames, checked against a frame-level reference model of the register protocol.
module tb_rs232_reg_responder;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] rxData = '0;
    logic       rxDone = 1'b0;
    logic       txBusy = 1'b0;
    logic [7:0] txData;
    logic       txTrg;
    logic       wrStb;
    logic [7:0] locAddr = '0;
    logic [7:0] locData;
    logic [7:0] errCnt;

    rs232_reg_responder #(.TIMEOUT_CYC(T), .ERR_W(8)) dut (
        .CLK_50MHZ(clk),
        .RST      (rstN),
        .RX_DATA  (rxData),
        .RX_DONE  (rxDone),
        .TX_BUSY  (txBusy),
        .TX_DATA  (txData),
        .TX_TRG   (txTrg),
        .WR_STB   (wrStb),
        .LOC_ADDR (locAddr),
        .LOC_DATA (locData),
        .ERR_CNT  (errCnt)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: register contents, error count, partial frame, pending reply.
    logic [7:0] refMem [256];
    int         refErr = 0;
    logic [7:0] frm [$];
    int         idleRun = 0;
    bit         holdResp = 0;
    bit         respPending = 0;
    logic [7:0] pendData = '0;
    int         refTrg = 0;
    int         refWr = 0;

    int         trgCount = 0;
    int         wrCount = 0;
    logic       busyPrev = 1'b0;
    logic [7:0] pool [8];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Pulse counters and the rule that a trigger never follows a busy cycle.
    always @(negedge clk) begin
        if (txTrg) begin
            trgCount <= trgCount + 1;
            checkOutput("busyBeforeTrg", 32'(busyPrev), 32'd0);
        end
        if (wrStb) begin
            wrCount <= wrCount + 1;
        end
        busyPrev <= txBusy;
    end

    task automatic modelErr();
        if (refErr < 255) refErr++;
    endtask

    // Idle cycles; a partial frame dies on the first idle cycle past T.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            idleRun++;
            if ((frm.size() == 1 || frm.size() == 2) && idleRun == T + 1) begin
                frm.delete();
                modelErr();
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxData = b;
        rxDone = 1'b1;
        @(posedge clk); #1;
        rxDone = 1'b0;
        idleRun = 0;
    endtask

    task automatic finishFrame();
        logic [7:0] op, a, d, old;
        logic       locHeld;
        op = frm[0]; a = frm[1]; d = frm[2];
        frm.delete();
        if (op == 8'h00) begin
            old = refMem[a];
            refMem[a] = d;
            refWr++;
            locHeld = (locAddr == a);
            @(negedge clk);
            checkOutput("wrStbPulse", 32'(wrStb), 32'd1);
            if (locHeld) checkOutput("locOldT1", 32'(locData), 32'(old));
            @(negedge clk);
            checkOutput("wrStbEnd", 32'(wrStb), 32'd0);
            if (locHeld) checkOutput("locOldT2", 32'(locData), 32'(old));
            @(negedge clk);
            if (locHeld) checkOutput("locNewT3", 32'(locData), 32'(d));
            @(posedge clk); #1;
        end else if (holdResp) begin
            respPending = 1;
            pendData = refMem[a];
        end else begin
            @(negedge clk);
            checkOutput("trgT1", 32'(txTrg), 32'd0);
            @(negedge clk);
            checkOutput("trgT2", 32'(txTrg), 32'd0);
            checkOutput("txDataT2", 32'(txData), 32'(refMem[a]));
            @(negedge clk);
            checkOutput("trgT3", 32'(txTrg), 32'd1);
            checkOutput("txDataT3", 32'(txData), 32'(refMem[a]));
            refTrg++;
            @(posedge clk); #1;
        end
    endtask

    task automatic pushByte(input logic [7:0] b, input int gap);
        idleCycles(gap);
        applyStimulus(b);
        if (respPending) begin
            modelErr();
        end else if (frm.size() == 0) begin
            if (b == 8'h00 || b == 8'h01) frm.push_back(b);
            else modelErr();
        end else begin
            frm.push_back(b);
        end
        checkOutput("errCnt", 32'(errCnt), 32'(refErr));
        if (frm.size() == 3) finishFrame();
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d, input int gap);
        pushByte(op, gap);
        pushByte(a, gap);
        pushByte(d, gap);
    endtask

    task automatic releaseTx();
        idleCycles(1);
        txBusy = 1'b0;
        @(negedge clk);
        checkOutput("trgHeld", 32'(txTrg), 32'd0);
        @(negedge clk);
        checkOutput("trgRelease", 32'(txTrg), 32'd1);
        checkOutput("txDataRelease", 32'(txData), 32'(pendData));
        @(negedge clk);
        checkOutput("trgSingle", 32'(txTrg), 32'd0);
        @(posedge clk); #1;
        respPending = 0;
        holdResp = 0;
        refTrg++;
    endtask

    task automatic checkLoc(input logic [7:0] a);
        locAddr = a;
        idleCycles(1);
        checkOutput("locData", 32'(locData), 32'(refMem[a]));
    endtask

    task automatic doReset();
        rstN = 1'b0;
        #1;
        checkOutput("rstTxData", 32'(txData), 32'd0);
        checkOutput("rstTxTrg", 32'(txTrg), 32'd0);
        checkOutput("rstWrStb", 32'(wrStb), 32'd0);
        checkOutput("rstLocData", 32'(locData), 32'd0);
        checkOutput("rstErrCnt", 32'(errCnt), 32'd0);
        for (int i = 0; i < 256; i++) refMem[i] = '0;
        refErr = 0;
        frm.delete();
        respPending = 0;
        holdResp = 0;
        rxDone = 1'b0;
        txBusy = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rstN = 1'b1;
        idleRun = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = '0;
        @(posedge clk); #1;
        doReset();

        // Write then local read.
        checkLoc(8'd123);
        sendFrame(8'h00, 8'd123, 8'd2, 0);
        checkLoc(8'd123);
        checkLoc(8'd0);
        checkLoc(8'd255);

        // Write/read round trip.
        sendFrame(8'h00, 8'd234, 8'd3, 1);
        sendFrame(8'h00, 8'd89, 8'd5, 0);
        sendFrame(8'h00, 8'd200, 8'd7, 2);
        sendFrame(8'h00, 8'd55, 8'd11, 0);
        sendFrame(8'h01, 8'd123, 8'hFF, 0);
        sendFrame(8'h01, 8'd234, 8'hFF, 1);
        sendFrame(8'h01, 8'd89, 8'hFF, 0);
        sendFrame(8'h01, 8'd200, 8'hFF, 3);
        sendFrame(8'h01, 8'd55, 8'hFF, 0);

        // Bad flow, then a valid write.
        pushByte(8'h03, 0);
        sendFrame(8'h00, 8'd10, 8'h44, 0);
        checkLoc(8'd10);

        // Byte dropped while a reply is waiting for the transmitter.
        txBusy = 1'b1;
        holdResp = 1;
        sendFrame(8'h01, 8'd89, 8'hFF, 0);
        idleCycles(3);
        pushByte(8'h77, 0);
        idleCycles(2);
        releaseTx();

        // Timeout abort, recovery and the exact-boundary byte.
        pushByte(8'h00, 0);
        pushByte(8'd123, 0);
        idleCycles(T + 1);
        checkOutput("errAfterTimeout", 32'(errCnt), 32'(refErr));
        checkLoc(8'd123);
        sendFrame(8'h00, 8'd123, 8'd9, 0);
        checkLoc(8'd123);
        sendFrame(8'h00, 8'd123, 8'h21, T);
        checkLoc(8'd123);

        // Long transmitter backpressure.
        txBusy = 1'b1;
        holdResp = 1;
        sendFrame(8'h01, 8'd123, 8'hFF, 0);
        idleCycles(1000);
        releaseTx();

        // Randomized frames.
        for (int i = 0; i < 8; i++) pool[i] = 8'($urandom);
        for (int n = 0; n < 80; n++) begin
            int kind;
            logic [7:0] a;
            kind = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 7)];
            if (kind <= 3) begin
                sendFrame(8'h00, a, 8'($urandom), ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, 3));
            end else if (kind <= 6) begin
                if ($urandom_range(0, 2) == 0) begin
                    txBusy = 1'b1;
                    holdResp = 1;
                    sendFrame(8'h01, a, 8'($urandom), $urandom_range(0, 2));
                    idleCycles($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) pushByte(8'($urandom), 0);
                    releaseTx();
                end else begin
                    sendFrame(8'h01, a, 8'($urandom), $urandom_range(0, 3));
                end
            end else if (kind == 7) begin
                pushByte(8'($urandom_range(2, 255)), $urandom_range(0, 3));
            end else if (kind == 8) begin
                pushByte(8'($urandom_range(0, 1)), 0);
                if ($urandom_range(0, 1) == 1) pushByte(a, 1);
                idleCycles(T + 1 + $urandom_range(0, 3));
                checkOutput("errRandTimeout", 32'(errCnt), 32'(refErr));
            end else begin
                checkLoc(a);
            end
        end

        // Reset in the middle of a frame.
        pushByte(8'h00, 0);
        pushByte(8'd55, 0);
        doReset();
        checkLoc(8'd55);
        checkLoc(8'd123);

        // Reset while a reply waits on the transmitter.
        sendFrame(8'h00, 8'd7, 8'h5A, 0);
        txBusy = 1'b1;
        holdResp = 1;
        sendFrame(8'h01, 8'd7, 8'hFF, 0);
        idleCycles(5);
        doReset();
        idleCycles(20);
        checkLoc(8'd7);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) pushByte(8'h03, 0);
        checkOutput("errSaturated", 32'(errCnt), 32'd255);

        idleCycles(3);
        checkOutput("trgTotal", 32'(trgCount), 32'(refTrg));
        checkOutput("wrTotal", 32'(wrCount), 32'(refWr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
